// File: rtl/alu_seq_ctrl.sv
// rtl/alu_seq_ctrl.sv - instruction sequencer FSM for the 16-register ALU datapath
//
// Purpose:
//    Accepts one 16-bit instruction per valid/ready handshake, captures it, and
//    steps IDLE -> DECODE -> EXECUTE -> WRITEBACK, driving the datapath controls.
//
// Ports:
//    clk          in   1   rising-edge clock
//    reset        in   1   asynchronous active-low reset
//    instr        in   16  [15:12] major, [11:8] Rdest, [7:4] ext/imm hi, [3:0] Rsrc/imm lo
//    instr_valid  in   1   instr is valid
//    instr_ready  out  1   FSM is in IDLE (decoded from state only)
//    sel_a        out  4   operand-A register select
//    sel_b        out  4   operand-B register select
//    imm_sel      out  1   operand B comes from imm_out
//    imm_out      out  16  sign-extended immediate
//    alu_op       out  8   ALU opcode
//    buff_en      out  1   result buffer enable (EXECUTE, WRITEBACK)
//    reg_en       out  16  one-hot register write enable (WRITEBACK)
//    busy         out  1   FSM not in IDLE
//    done         out  1   one-cycle retire pulse (WRITEBACK)
//    retired_cnt  out  16  retired-instruction count (only with ALU_SEQ_CTRL_CNT_EN)
//
// Configuration macro: ALU_SEQ_CTRL_CNT_EN adds the retired_cnt port and counter.

module alu_seq_ctrl (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] instr,
   input  logic        instr_valid,
   output logic        instr_ready,
   output logic [3:0]  sel_a,
   output logic [3:0]  sel_b,
   output logic        imm_sel,
   output logic [15:0] imm_out,
   output logic [7:0]  alu_op,
   output logic        buff_en,
   output logic [15:0] reg_en,
   output logic        busy,
   output logic        done
`ifdef ALU_SEQ_CTRL_CNT_EN
   ,
   output logic [15:0] retired_cnt
`endif
);

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_DECODE    = 2'd1,
      S_EXECUTE   = 2'd2,
      S_WRITEBACK = 2'd3
   } state_t;

   state_t      r_state;
   state_t      w_next_state;
   logic [15:0] r_instr;

   logic        w_accept;
   logic [15:0] w_src;
   logic [3:0]  w_major;
   logic [3:0]  w_rdest;
   logic [3:0]  w_ext;
   logic [3:0]  w_rsrc;
   logic [7:0]  w_alu_op;
   logic        w_imm_sel;
   logic [15:0] w_imm_out;
   logic        w_is_cmp;

   logic [3:0]  w_sel_a_nxt;
   logic [3:0]  w_sel_b_nxt;
   logic        w_imm_sel_nxt;
   logic [15:0] w_imm_out_nxt;
   logic [7:0]  w_alu_op_nxt;
   logic        w_buff_en_nxt;
   logic [15:0] w_reg_en_nxt;
   logic        w_done_nxt;

   assign instr_ready = (r_state == S_IDLE);
   assign busy        = (r_state != S_IDLE);
   assign w_accept    = instr_valid && instr_ready;

   // On the accept edge the outputs must already reflect the new instruction,
   // so decode the live input then; afterwards decode the captured copy.
   assign w_src   = w_accept ? instr : r_instr;
   assign w_major = w_src[15:12];
   assign w_rdest = w_src[11:8];
   assign w_ext   = w_src[7:4];
   assign w_rsrc  = w_src[3:0];

   always_comb begin
      w_alu_op  = 8'h00;
      w_imm_sel = 1'b0;
      w_imm_out = 16'h0000;
      if (w_major == 4'h0) begin
         w_alu_op = {4'h0, w_ext};
      end else begin
         w_alu_op  = {w_major, 4'h0};
         w_imm_sel = 1'b1;
         w_imm_out = {{8{w_src[7]}}, w_src[7:0]};
      end
   end

   // Compare ops only update flags, so they never write the register bank.
   assign w_is_cmp = (w_alu_op == 8'h0B) || (w_alu_op == 8'hB0);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
         r_instr <= 16'h0000;
      end else begin
         r_state <= w_next_state;
         if (w_accept) begin
            r_instr <= instr;
         end
      end
   end

   // Next state plus next values of the registered outputs, keyed on the
   // state being entered so each flop shows its value during that state.
   always_comb begin
      w_next_state  = r_state;
      w_sel_a_nxt   = 4'h0;
      w_sel_b_nxt   = 4'h0;
      w_imm_sel_nxt = 1'b0;
      w_imm_out_nxt = 16'h0000;
      w_alu_op_nxt  = 8'h00;
      w_buff_en_nxt = 1'b0;
      w_reg_en_nxt  = 16'h0000;
      w_done_nxt    = 1'b0;

      case (r_state)
         S_IDLE:      if (w_accept) w_next_state = S_DECODE;
         S_DECODE:    w_next_state = S_EXECUTE;
         S_EXECUTE:   w_next_state = S_WRITEBACK;
         S_WRITEBACK: w_next_state = S_IDLE;
         default:     w_next_state = S_IDLE;
      endcase

      if (w_next_state != S_IDLE) begin
         w_sel_a_nxt   = w_rdest;
         w_sel_b_nxt   = w_rsrc;
         w_imm_sel_nxt = w_imm_sel;
         w_imm_out_nxt = w_imm_out;
         w_alu_op_nxt  = w_alu_op;
      end
      if ((w_next_state == S_EXECUTE) || (w_next_state == S_WRITEBACK)) begin
         w_buff_en_nxt = 1'b1;
      end
      if (w_next_state == S_WRITEBACK) begin
         w_done_nxt = 1'b1;
         if (!w_is_cmp) begin
            w_reg_en_nxt = 16'h0001 << w_rdest;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sel_a   <= 4'h0;
         sel_b   <= 4'h0;
         imm_sel <= 1'b0;
         imm_out <= 16'h0000;
         alu_op  <= 8'h00;
         buff_en <= 1'b0;
         reg_en  <= 16'h0000;
         done    <= 1'b0;
      end else begin
         sel_a   <= w_sel_a_nxt;
         sel_b   <= w_sel_b_nxt;
         imm_sel <= w_imm_sel_nxt;
         imm_out <= w_imm_out_nxt;
         alu_op  <= w_alu_op_nxt;
         buff_en <= w_buff_en_nxt;
         reg_en  <= w_reg_en_nxt;
         done    <= w_done_nxt;
      end
   end

`ifdef ALU_SEQ_CTRL_CNT_EN
   logic [15:0] r_retired_cnt;

   // Counts at the edge that ends the done pulse; wraps naturally at 16 bits.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_retired_cnt <= 16'h0000;
      end else if (done) begin
         r_retired_cnt <= r_retired_cnt + 16'h0001;
      end
   end

   assign retired_cnt = r_retired_cnt;
`endif

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb/tb_alu_seq_ctrl.sv - self-checking bench for alu_seq_ctrl

module tb_alu_seq_ctrl;

   logic        clk;
   logic        reset;
   logic [15:0] instr;
   logic        instr_valid;
   logic        instr_ready;
   logic [3:0]  sel_a;
   logic [3:0]  sel_b;
   logic        imm_sel;
   logic [15:0] imm_out;
   logic [7:0]  alu_op;
   logic        buff_en;
   logic [15:0] reg_en;
   logic        busy;
   logic        done;
`ifdef ALU_SEQ_CTRL_CNT_EN
   logic [15:0] retired_cnt;
`endif

   int n_checks = 0;
   int n_errors = 0;

   alu_seq_ctrl dut (
      .clk         (clk),
      .reset       (reset),
      .instr       (instr),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .sel_a       (sel_a),
      .sel_b       (sel_b),
      .imm_sel     (imm_sel),
      .imm_out     (imm_out),
      .alu_op      (alu_op),
      .buff_en     (buff_en),
      .reg_en      (reg_en),
      .busy        (busy),
      .done        (done)
`ifdef ALU_SEQ_CTRL_CNT_EN
      ,
      .retired_cnt (retired_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] in;
      logic [7:0]  alu;
      logic [15:0] imm;
      logic        isel;
      logic [15:0] re;
      string       nm;
   } vec_t;

   vec_t tbl[6];

   // {instr_ready, busy, sel_a, sel_b, imm_sel, imm_out, alu_op, buff_en, reg_en, done}
   function automatic logic [52:0] outs();
      return {instr_ready, busy, sel_a, sel_b, imm_sel, imm_out, alu_op, buff_en, reg_en, done};
   endfunction

   // Expected outputs during phase ph after accept: 1 DECODE, 2 EXECUTE,
   // 3 WRITEBACK, anything else IDLE.
   function automatic logic [52:0] expv(input int ph, input logic [15:0] in, input logic [7:0] a,
                                        input logic [15:0] im, input logic isel, input logic [15:0] re);
      logic act;
      act = (ph >= 1) && (ph <= 3);
      return {!act, act,
              act ? in[11:8] : 4'h0,
              act ? in[3:0]  : 4'h0,
              act & isel,
              act ? im : 16'h0000,
              act ? a  : 8'h00,
              (ph == 2) || (ph == 3),
              (ph == 3) ? re : 16'h0000,
              ph == 3};
   endfunction

   // Reference decode from the field arithmetic of the instruction word.
   task automatic model(input logic [15:0] in, output logic [7:0] a, output logic [15:0] im,
                        output logic isel, output logic [15:0] re);
      int major, rd, ext, low8, op;
      major = int'(in) / 4096;
      rd    = (int'(in) / 256) % 16;
      ext   = (int'(in) / 16) % 16;
      low8  = int'(in) % 256;
      if (major == 0) begin
         op = ext; im = 16'd0; isel = 1'b0;
      end else begin
         op = major * 16; isel = 1'b1;
         im = (low8 >= 128) ? 16'(low8 + 65280) : 16'(low8);
      end
      a  = 8'(op);
      re = (op == 11 || op == 176) ? 16'd0 : 16'(1 << rd);
   endtask

   task automatic chk(input string nm, input logic [52:0] got, input logic [52:0] want);
      n_checks++;
      if (got !== want) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h", nm, got, want);
      end
   endtask

   task automatic chk16(input string nm, input logic [15:0] got, input logic [15:0] want);
      n_checks++;
      if (got !== want) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h", nm, got, want);
      end
   endtask

   // Present one instruction, wait (bounded) for the accept, scramble instr
   // afterwards, and check all outputs across DECODE..IDLE.
   task automatic run_one(input logic [15:0] in, input logic [7:0] a, input logic [15:0] im,
                          input logic isel, input logic [15:0] re, input string nm);
      bit ok;
      ok = 0;
      @(negedge clk);
      instr = in;
      instr_valid = 1'b1;
      for (int k = 0; k < 10; k++) begin
         if (instr_ready) begin ok = 1; break; end
         @(negedge clk);
      end
      if (!ok) begin
         n_checks++; n_errors++;
         $display("FAIL %s accept_timeout got_ready=%b exp_ready=1", nm, instr_ready);
         instr_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      instr_valid = 1'b0;
      instr = 16'($urandom);
      for (int ph = 1; ph <= 4; ph++) begin
         @(negedge clk);
         instr = 16'($urandom);
         chk($sformatf("%s_ph%0d", nm, ph), outs(), expv(ph, in, a, im, isel, re));
      end
   endtask

   logic [7:0]  m_a;
   logic [15:0] m_im;
   logic        m_isel;
   logic [15:0] m_re;

   initial begin
      tbl[0] = '{16'h0553, 8'h05, 16'h0000, 1'b0, 16'h0020, "reg_add"};
      tbl[1] = '{16'h52F0, 8'h50, 16'hFFF0, 1'b1, 16'h0004, "imm_neg"};
      tbl[2] = '{16'h0BB1, 8'h0B, 16'h0000, 1'b0, 16'h0000, "cmp_reg"};
      tbl[3] = '{16'hB07F, 8'hB0, 16'h007F, 1'b1, 16'h0000, "cmp_imm"};
      tbl[4] = '{16'h1F80, 8'h10, 16'hFF80, 1'b1, 16'h8000, "imm_r15"};
      tbl[5] = '{16'h0E01, 8'h00, 16'h0000, 1'b0, 16'h4000, "reg_ext0"};

      // Reset held with a valid instruction waiting.
      reset = 1'b0;
      instr_valid = 1'b1;
      instr = 16'h0553;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk($sformatf("reset_hold%0d", c), outs(), expv(0, 16'h0, 8'h0, 16'h0, 1'b0, 16'h0));
      end
`ifdef ALU_SEQ_CTRL_CNT_EN
      chk16("reset_cnt", retired_cnt, 16'h0000);
`endif
      // Release: accept on the first edge after release.
      reset = 1'b1;
      @(posedge clk);
      #1;
      instr_valid = 1'b0;
      instr = 16'hFFFF;
      for (int ph = 1; ph <= 4; ph++) begin
         @(negedge clk);
         chk($sformatf("post_reset_ph%0d", ph), outs(), expv(ph, 16'h0553, 8'h05, 16'h0000, 1'b0, 16'h0020));
      end

      // Directed table.
      for (int i = 0; i < 6; i++) begin
         run_one(tbl[i].in, tbl[i].alu, tbl[i].imm, tbl[i].isel, tbl[i].re, tbl[i].nm);
      end

      // Back-to-back with instr_valid held; junk on instr while busy.
      begin
         logic [15:0] prog[3];
         int acc[3];
         int n;
         prog[0] = 16'h0553; prog[1] = 16'h1F80; prog[2] = 16'h0BB1;
         n = 0;
         @(negedge clk);
         instr_valid = 1'b1;
         for (int cyc = 0; cyc < 16; cyc++) begin
            for (int j = 0; j < n; j++) begin
               if (cyc == acc[j] + 1 || cyc == acc[j] + 3) begin
                  model(prog[j], m_a, m_im, m_isel, m_re);
                  chk($sformatf("b2b_i%0d_ph%0d", j, cyc - acc[j]), outs(),
                      expv(cyc - acc[j], prog[j], m_a, m_im, m_isel, m_re));
               end
            end
            if (instr_ready && n < 3) begin
               acc[n] = cyc;
               instr = prog[n];
               n++;
            end else begin
               instr = 16'($urandom);
               if (n == 3 && instr_ready) instr_valid = 1'b0;
            end
            @(negedge clk);
         end
         instr_valid = 1'b0;
         n_checks++;
         if (n != 3) begin
            n_errors++;
            $display("FAIL b2b_accepts got=%0d exp=3", n);
         end else begin
            chk16("b2b_gap1", 16'(acc[1] - acc[0]), 16'd4);
            chk16("b2b_gap2", 16'(acc[2] - acc[1]), 16'd4);
         end
      end

      // Reset asserted during EXECUTE: immediate abort, no write, no done.
      @(negedge clk);
      instr = 16'h0553;
      instr_valid = 1'b1;
      @(posedge clk);
      #1;
      instr_valid = 1'b0;
      @(negedge clk);
      chk("abort_decode", outs(), expv(1, 16'h0553, 8'h05, 16'h0, 1'b0, 16'h0020));
      @(negedge clk);
      chk("abort_execute", outs(), expv(2, 16'h0553, 8'h05, 16'h0, 1'b0, 16'h0020));
      reset = 1'b0;
      #1;
      chk("abort_async", outs(), expv(0, 16'h0, 8'h0, 16'h0, 1'b0, 16'h0));
      @(negedge clk);
      chk("abort_no_wb", outs(), expv(0, 16'h0, 8'h0, 16'h0, 1'b0, 16'h0));
`ifdef ALU_SEQ_CTRL_CNT_EN
      chk16("abort_cnt", retired_cnt, 16'h0000);
`endif
      reset = 1'b1;

      // Randomized instructions against the reference model.
      for (int r = 0; r < 40; r++) begin
         logic [15:0] ri;
         ri = 16'($urandom);
         if ($urandom_range(0, 5) == 0) ri = {4'h0, ri[11:8], 4'hB, ri[3:0]};
         if ($urandom_range(0, 5) == 0) ri = {4'hB, ri[11:0]};
         model(ri, m_a, m_im, m_isel, m_re);
         run_one(ri, m_a, m_im, m_isel, m_re, $sformatf("rnd%0d_%h", r, ri));
      end
`ifdef ALU_SEQ_CTRL_CNT_EN
      chk16("cnt_after_rnd", retired_cnt, 16'd40);
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
